// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, mid-bit sample points and the receiver state enum.
package uart_pkg;

    localparam int         UART_DATA_WIDTH   = 8;
    localparam int         UART_OVERSAMPLE   = 16;
    localparam logic [3:0] START_SAMPLE_TICK = 4'd7;
    localparam logic [3:0] BIT_SAMPLE_TICK   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: ready/valid data plus status pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_WIDTH-1:0] rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic                       rx_active;
    logic                       frame_err;
    logic                       rx_overrun;

    modport master (
        output rx_data, rx_valid, rx_active, frame_err, rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_active, frame_err, rx_overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous input that idles high; all flops reset to 1.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: start-edge detect, mid-bit sampling on a 16x tick, ready/valid byte output.
// Define UART_RX_MAJORITY_EN to make each bit decision a 2-of-3 vote over the last three ticks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = UART_DATA_WIDTH,
    parameter int OVERSAMPLE_RATE = UART_OVERSAMPLE,
    parameter int SYNC_STAGES     = 2
) (
    input  logic      uart_clk,
    input  logic      rst_n,
    input  logic      baud_tick,
    input  logic      rx_serial,
    uart_rx_if.master rx_if
);

    localparam int TW = $clog2(OVERSAMPLE_RATE);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [TW-1:0] LP_START_TICK = TW'(START_SAMPLE_TICK);
    localparam logic [TW-1:0] LP_BIT_TICK   = TW'(BIT_SAMPLE_TICK);
    localparam logic [BW-1:0] LP_LAST_BIT   = BW'(DATA_WIDTH - 1);

    uart_rx_state_t        r_state;
    uart_rx_state_t        w_state_nxt;
    logic                  w_rx_s;
    logic                  r_rx_s_d;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  w_fall;
    logic                  w_at_start;
    logic                  w_at_bit;
    logic                  w_bit;
    logic                  w_shift;
    logic                  w_done;
    logic                  w_stop_err;
    logic                  r_done;
    logic                  r_stop_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_overrun;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (uart_clk),
        .rst_n   (rst_n),
        .i_async (rx_serial),
        .o_sync  (w_rx_s)
    );

    assign w_fall     = r_rx_s_d & ~w_rx_s;
    assign w_at_start = baud_tick && (r_state == START) && (r_tick_cnt == LP_START_TICK);
    assign w_at_bit   = baud_tick && ((r_state == DATA) || (r_state == STOP))
                        && (r_tick_cnt == LP_BIT_TICK);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] LP_START_M2 = TW'(START_SAMPLE_TICK - 4'd2);
    localparam logic [TW-1:0] LP_START_M1 = TW'(START_SAMPLE_TICK - 4'd1);
    localparam logic [TW-1:0] LP_BIT_M2   = TW'(BIT_SAMPLE_TICK - 4'd2);
    localparam logic [TW-1:0] LP_BIT_M1   = TW'(BIT_SAMPLE_TICK - 4'd1);

    logic r_samp_a;
    logic r_samp_b;

    // The two earlier votes are captured on the ticks just before each decision tick.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else if (baud_tick) begin
            if ((r_tick_cnt == LP_START_M2) || (r_tick_cnt == LP_BIT_M2)) r_samp_a <= w_rx_s;
            if ((r_tick_cnt == LP_START_M1) || (r_tick_cnt == LP_BIT_M1)) r_samp_b <= w_rx_s;
        end
    end

    assign w_bit = maj3(r_samp_a, r_samp_b, w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_stop_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (w_at_start) w_state_nxt = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_at_bit) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LP_LAST_BIT) w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                if (w_at_bit) begin
                    w_state_nxt = IDLE;
                    w_done      = w_bit;
                    w_stop_err  = ~w_bit;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_rx_s_d   <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_done     <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_rx_s_d   <= w_rx_s;
            r_done     <= w_done;
            r_stop_err <= w_stop_err;
            if (r_state == IDLE) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (baud_tick) begin
                r_tick_cnt <= (w_at_start && !w_bit) ? '0 : r_tick_cnt + 1'b1;
            end
            if (w_shift) begin
                r_shreg   <= {w_bit, r_shreg[DATA_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // A pending byte blocks the new one unless it is being consumed in the same cycle.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= r_stop_err;
            r_overrun   <= 1'b0;
            if (r_done && (!r_valid || rx_if.rx_ready)) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_done) begin
                r_overrun <= 1'b1;
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = r_data;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.rx_active  = (r_state != IDLE);
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: slot-level line model (one slot per baud tick) predicts bytes and pulses.
module tb_uart_rx;

    typedef struct {
        int         at;
        bit         ferr;
        logic [7:0] d;
    } ev_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_serial = 1'b1;
    int   rdy_mode  = 1;

    uart_rx_if rx_if();

    uart_rx dut (
        .uart_clk  (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .rx_serial (rx_serial),
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    ev_t        evq[$];
    logic [7:0] got[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       x_ferr;
    logic       x_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0:       rx_if.rx_ready = 1'b0;
            1:       rx_if.rx_ready = 1'b1;
            default: rx_if.rx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output-side model: completions land on a known edge, the byte register follows ready/valid rules.
    always @(posedge clk) begin : cmp
        logic       rdy;
        logic       rst_now;
        logic       done;
        logic [7:0] nd;
        ev_t        e;
        cyc++;
        rdy     = rx_if.rx_ready;
        rst_now = !rst_n;
        if (!rst_now && rx_if.rx_valid && rdy) got.push_back(rx_if.rx_data);
        x_ferr = 1'b0;
        x_ovr  = 1'b0;
        done   = 1'b0;
        nd     = 8'h00;
        if (rst_now) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            while (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.ferr) x_ferr = 1'b1;
                else begin
                    done = 1'b1;
                    nd   = e.d;
                end
            end
            if (done && (!m_valid || rdy)) begin
                m_valid = 1'b1;
                m_data  = nd;
            end else if (done) begin
                x_ovr = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
        if (rx_if.frame_err)  n_ferr++;
        if (rx_if.rx_overrun) n_ovr++;
        chk("rx_valid",   32'(rx_if.rx_valid),   32'(m_valid));
        chk("rx_data",    32'(rx_if.rx_data),    32'(m_data));
        chk("frame_err",  32'(rx_if.frame_err),  32'(x_ferr));
        chk("rx_overrun", 32'(rx_if.rx_overrun), 32'(x_ovr));
    end

    // One slot = 4 clocks; line changes right after a tick, tick edge returned in tedge.
    task automatic slot(input logic v, output int tedge);
        rx_serial = v;
        baud_tick = 1'b0;
        repeat (3) @(negedge clk);
        baud_tick = 1'b1;
        tedge = cyc + 1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        int te;
        for (int i = 0; i < n; i++) slot(1'b1, te);
    endtask

    function automatic logic decide(input logic s[160], input int i);
`ifdef UART_RX_MAJORITY_EN
        return (s[i-2] & s[i-1]) | (s[i-2] & s[i]) | (s[i-1] & s[i]);
`else
        return s[i];
`endif
    endfunction

    // Start bit slots 0..15, data bit b at 16+16b.., stop 144..159; decisions at 7, 23+16b, 151.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch, input int abort_at);
        logic       s[160];
        logic [7:0] bits;
        logic       stop_dec;
        ev_t        e;
        int         te;
        for (int i = 0; i < 160; i++)
            s[i] = (i < 16) ? 1'b0 : (i < 144) ? d[(i - 16) / 16] : stop;
        if (glitch >= 0) s[glitch] = ~s[glitch];
        for (int b = 0; b < 8; b++) bits[b] = decide(s, 23 + 16 * b);
        stop_dec = decide(s, 151);
        for (int i = 0; i < 160; i++) begin
            if (i == abort_at) return;
            slot(s[i], te);
            if (i == 151) begin
                e.at   = te + 1;
                e.ferr = !stop_dec;
                e.d    = bits;
                evq.push_back(e);
            end
        end
    endtask

    function automatic logic [31:0] pop_got();
        if (got.size() == 0) return 32'hDEAD;
        return 32'(got.pop_front());
    endfunction

    initial begin
        int te;
        int f0;
        int o0;
        logic [7:0] d;
        logic       st;
        int         gl;

        repeat (3) @(negedge clk);
        chk("reset_valid",  32'(rx_if.rx_valid),   0);
        chk("reset_active", 32'(rx_if.rx_active),  0);
        chk("reset_data",   32'(rx_if.rx_data),    0);
        rst_n = 1'b1;
        idle(4);

        send_frame(8'hA5, 1'b1, -1, -1);
        idle(4);
        chk("t1_count", got.size(), 1);
        chk("t1_data",  pop_got(), 32'hA5);
        chk("t1_ferr",  n_ferr, 0);

        slot(1'b0, te);
        slot(1'b0, te);
        chk("t2_active_hi", 32'(rx_if.rx_active), 1);
        slot(1'b0, te);
        slot(1'b0, te);
        idle(12);
        chk("t2_active_lo", 32'(rx_if.rx_active), 0);
        chk("t2_no_byte",   got.size(), 0);
        chk("t2_no_ferr",   n_ferr, 0);

        send_frame(8'h3C, 1'b0, -1, -1);
        for (int i = 0; i < 480; i++) slot(1'b0, te);
        idle(8);
        chk("t3_ferr_once", n_ferr, 1);
        chk("t3_no_byte",   got.size(), 0);

        rdy_mode = 0;
        o0 = n_ovr;
        idle(2);
        send_frame(8'h11, 1'b1, -1, -1);
        idle(4);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(4);
        chk("t4_held_data",  32'(rx_if.rx_data),  32'h11);
        chk("t4_held_valid", 32'(rx_if.rx_valid), 1);
        chk("t4_overrun",    n_ovr - o0, 1);
        rdy_mode = 1;
        idle(2);
        chk("t4_count", got.size(), 1);
        chk("t4_data",  pop_got(), 32'h11);

        send_frame(8'h5A, 1'b1, -1, 80);
        rst_n     = 1'b0;
        rx_serial = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_active", 32'(rx_if.rx_active), 0);
        chk("t5_valid",  32'(rx_if.rx_valid),  0);
        chk("t5_data",   32'(rx_if.rx_data),   0);
        idle(4);
        send_frame(8'hF0, 1'b1, -1, -1);
        idle(4);
        chk("t5_count", got.size(), 1);
        chk("t5_data2", pop_got(), 32'hF0);

        send_frame(8'h00, 1'b1, 70, -1);
        idle(4);
        chk("t6_tick14", pop_got(), 32'h00);
        send_frame(8'h00, 1'b1, 71, -1);
        idle(4);
`ifdef UART_RX_MAJORITY_EN
        chk("t6_tick15", pop_got(), 32'h00);
`else
        chk("t6_tick15", pop_got(), 32'h08);
`endif

        rdy_mode = 2;
        f0 = n_ferr;
        for (int k = 0; k < 25; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            gl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(16, 150)) : -1;
            send_frame(d, st, gl, -1);
            idle(int'($urandom_range(1, 6)));
        end
        rdy_mode = 1;
        idle(4);
        chk("rand_drain", evq.size(), 0);
        chk("rand_ferr_seen", 32'(n_ferr >= f0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
